// File: rtl/ft245_bus_arbiter.sv
// ft245_bus_arbiter: round-robin owner of the half-duplex FT245 data bus, with per-grant burst limit and turnaround gap.
// Define FT245_SIWU_EN to build the send-immediate (siwu_n) idle timer; otherwise siwu_n is tied high.
module ft245_bus_arbiter #(
    parameter int MAX_BURST    = 64,
    parameter int TURN_CYCLES  = 2,
    parameter int BCNT_W       = 8,
    parameter int SIWU_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_avail,
    input  logic              tx_ready,
    input  logic              in_fifo_full,
    input  logic              out_fifo_empty,
    input  logic              rx_beat,
    input  logic              tx_beat,
    input  logic              rx_idle,
    input  logic              tx_idle,
    output logic              rx_grant,
    output logic              tx_grant,
    output logic              rx_stop,
    output logic              tx_stop,
    output logic              bus_drive,
    output logic              last_dir,
    output logic [BCNT_W-1:0] beat_count,
    output logic              siwu_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RX_GRANT,
        S_TX_GRANT,
        S_TURN
    } state_t;

    localparam int                TCNT_W    = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TURN_LAST = TCNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic [BCNT_W-1:0] BURST_LIM = BCNT_W'(MAX_BURST);
    localparam bit                BURST_EN  = (MAX_BURST != 0);

    state_t            state_q;
    logic              rx_grant_q;
    logic              tx_grant_q;
    logic              rx_stop_q;
    logic              tx_stop_q;
    logic              last_dir_q;
    logic              held_q;
    logic [BCNT_W-1:0] beat_count_q;
    logic [BCNT_W-1:0] beat_count_d;
    logic [TCNT_W-1:0] turn_cnt_q;

    logic rx_req;
    logic tx_req;
    logic own_beat;
    logic own_idle;
    logic other_req;
    logic release_d;
    logic stop_d;

    // Steer the owning engine's beat/idle and the waiting side's request into one grant datapath.
    always_comb begin
        rx_req    = rx_avail & ~in_fifo_full;
        tx_req    = tx_ready & ~out_fifo_empty;
        own_beat  = 1'b0;
        own_idle  = 1'b0;
        other_req = 1'b0;
        case (state_q)
            S_RX_GRANT: begin
                own_beat  = rx_beat;
                own_idle  = rx_idle;
                other_req = tx_req;
            end
            S_TX_GRANT: begin
                own_beat  = tx_beat;
                own_idle  = tx_idle;
                other_req = rx_req;
            end
            default: begin
                own_beat  = 1'b0;
                own_idle  = 1'b0;
                other_req = 1'b0;
            end
        endcase

        beat_count_d = beat_count_q;
        if (own_beat && (beat_count_q != '1)) begin
            beat_count_d = beat_count_q + 1'b1;
        end

        // held_q marks the second grant cycle onward, so a grant always lasts at least two cycles.
        release_d = own_idle & held_q;
        stop_d    = BURST_EN && (beat_count_d >= BURST_LIM) && other_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rx_grant_q   <= 1'b0;
            tx_grant_q   <= 1'b0;
            rx_stop_q    <= 1'b0;
            tx_stop_q    <= 1'b0;
            last_dir_q   <= 1'b1;
            held_q       <= 1'b0;
            beat_count_q <= '0;
            turn_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_req && (!tx_req || last_dir_q)) begin
                        state_q      <= S_RX_GRANT;
                        rx_grant_q   <= 1'b1;
                        beat_count_q <= '0;
                        held_q       <= 1'b0;
                    end else if (tx_req) begin
                        state_q      <= S_TX_GRANT;
                        tx_grant_q   <= 1'b1;
                        beat_count_q <= '0;
                        held_q       <= 1'b0;
                    end
                end
                S_RX_GRANT, S_TX_GRANT: begin
                    beat_count_q <= beat_count_d;
                    held_q       <= 1'b1;
                    // Release wins over a stop raised in the same cycle, so that stop is never seen.
                    if (release_d) begin
                        rx_grant_q <= 1'b0;
                        tx_grant_q <= 1'b0;
                        rx_stop_q  <= 1'b0;
                        tx_stop_q  <= 1'b0;
                        last_dir_q <= (state_q == S_TX_GRANT);
                        turn_cnt_q <= '0;
                        state_q    <= (TURN_CYCLES == 0) ? S_IDLE : S_TURN;
                    end else if (stop_d) begin
                        if (state_q == S_RX_GRANT) begin
                            rx_stop_q <= 1'b1;
                        end else begin
                            tx_stop_q <= 1'b1;
                        end
                    end
                end
                S_TURN: begin
                    if (turn_cnt_q == TURN_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        turn_cnt_q <= turn_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_grant   = rx_grant_q;
    assign tx_grant   = tx_grant_q;
    assign rx_stop    = rx_stop_q;
    assign tx_stop    = tx_stop_q;
    assign bus_drive  = tx_grant_q;
    assign last_dir   = last_dir_q;
    assign beat_count = beat_count_q;

`ifdef FT245_SIWU_EN
    localparam int                SCNT_W    = $clog2(SIWU_TIMEOUT + 1);
    localparam logic [SCNT_W-1:0] SIWU_LAST = SCNT_W'(SIWU_TIMEOUT);

    logic              siwu_armed_q;
    logic              siwu_n_q;
    logic [SCNT_W-1:0] siwu_cnt_q;
    logic              tx_release;
    logic              siwu_block;

    assign tx_release = (state_q == S_TX_GRANT) & release_d;
    // An RX decision in IDLE counts as a grant so the pulse never lands on a grant edge.
    assign siwu_block = tx_req | rx_grant_q | tx_grant_q | ((state_q == S_IDLE) & rx_req);

    // Armed once per TX release that left the transmit FIFO empty; fires a single low pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            siwu_armed_q <= 1'b0;
            siwu_cnt_q   <= '0;
            siwu_n_q     <= 1'b1;
        end else begin
            siwu_n_q <= 1'b1;
            if (tx_release) begin
                siwu_armed_q <= out_fifo_empty;
                siwu_cnt_q   <= '0;
            end else if (siwu_armed_q) begin
                if (siwu_block) begin
                    siwu_armed_q <= 1'b0;
                    siwu_cnt_q   <= '0;
                end else if ((siwu_cnt_q + 1'b1) == SIWU_LAST) begin
                    siwu_n_q     <= 1'b0;
                    siwu_armed_q <= 1'b0;
                    siwu_cnt_q   <= '0;
                end else begin
                    siwu_cnt_q <= siwu_cnt_q + 1'b1;
                end
            end
        end
    end

    assign siwu_n = siwu_n_q;
`else
    assign siwu_n = 1'b1;
`endif

endmodule
